// File: rtl/mips_multicycle_control_pkg.sv
// Shared constants for the multicycle MIPS control path: opcode/funct codes,
// ALU control codes, mux encodings, FSM states and the per-state control word.
package mips_multicycle_control_pkg;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_BNE  = 6'b000101;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_J    = 6'b000010;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    localparam logic [2:0] ALU_ADD = 3'b001;
    localparam logic [2:0] ALU_SUB = 3'b101;
    localparam logic [2:0] ALU_AND = 3'b011;
    localparam logic [2:0] ALU_OR  = 3'b010;
    localparam logic [2:0] ALU_SLT = 3'b100;

    localparam logic [1:0] SRCB_B     = 2'b00;
    localparam logic [1:0] SRCB_FOUR  = 2'b01;
    localparam logic [1:0] SRCB_IMM   = 2'b10;
    localparam logic [1:0] SRCB_BRIMM = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10
    } aluop_t;

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_EXECUTE = 4'd6,
        S_ALUWB   = 4'd7,
        S_BRANCH  = 4'd8,
        S_ADDIEX  = 4'd9,
        S_ADDIWB  = 4'd10,
        S_JEX     = 4'd11
    } state_t;

    // alu_en gates alu_control so states that do not use the ALU drive zero.
    typedef struct packed {
        logic       pc_write;
        logic       branch;
        logic       branch_ne;
        logic       i_or_d;
        logic       mem_write;
        logic       ir_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic       alu_en;
        logic [1:0] pc_src;
        logic       illegal;
    } ctrl_t;

    function automatic logic op_supported(input logic [5:0] op);
        return op inside {OP_R, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_ADDI, OP_J};
    endfunction

endpackage

// File: rtl/mips_multicycle_control_if.sv
// Control-path bundle between the main FSM (master) and the datapath (slave).
interface mips_multicycle_control_if;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       zero;
    logic       mem_ready;
    logic       pc_en;
    logic       i_or_d;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_control;
    logic [1:0] pc_src;
    logic       illegal;

    modport master (
        input  opcode, funct, zero, mem_ready,
        output pc_en, i_or_d, mem_write, ir_write, reg_dst, mem_to_reg,
               reg_write, alu_src_a, alu_src_b, alu_control, pc_src, illegal
    );

    modport slave (
        output opcode, funct, zero, mem_ready,
        input  pc_en, i_or_d, mem_write, ir_write, reg_dst, mem_to_reg,
               reg_write, alu_src_a, alu_src_b, alu_control, pc_src, illegal
    );
endinterface

// File: rtl/mips_multicycle_control_alu_decoder.sv
// ALU decoder: maps aluop (and funct for R-type) to the 3-bit ALU control code.
module alu_decoder
    import mips_multicycle_control_pkg::*;
(
    input  aluop_t     i_aluop,
    input  logic [5:0] i_funct,
    output logic [2:0] o_alu_control,
    output logic       o_funct_illegal
);
    always_comb begin
        o_alu_control   = ALU_ADD;
        o_funct_illegal = 1'b0;
        case (i_aluop)
            ALUOP_SUB: o_alu_control = ALU_SUB;
            ALUOP_FUNCT: begin
                case (i_funct)
                    FN_ADD:  o_alu_control = ALU_ADD;
                    FN_SUB:  o_alu_control = ALU_SUB;
                    FN_AND:  o_alu_control = ALU_AND;
                    FN_OR:   o_alu_control = ALU_OR;
                    FN_SLT:  o_alu_control = ALU_SLT;
                    default: o_funct_illegal = 1'b1;
                endcase
            end
            default: ;
        endcase
    end
endmodule

// File: rtl/mips_multicycle_control.sv
// Main control FSM of the multicycle MIPS: state register, next-state logic,
// Moore output decode and the PC enable combine.
module mips_multicycle_control
    import mips_multicycle_control_pkg::*;
#(
    parameter bit HONOR_MEM_READY = 1'b1
) (
    input  logic                       clk,
    input  logic                       reset,
    mips_multicycle_control_if.master  bus
);
    state_t     r_state;
    state_t     w_next;
    ctrl_t      w_c;
    aluop_t     w_aluop;
    logic [2:0] w_alu_control;
    logic       w_funct_illegal;
    logic       w_ready;

    assign w_ready = HONOR_MEM_READY ? bus.mem_ready : 1'b1;

    // aluop depends on state only, keeping funct_illegal free of feedback loops.
    assign w_aluop = (r_state == S_EXECUTE) ? ALUOP_FUNCT :
                     (r_state == S_BRANCH)  ? ALUOP_SUB   : ALUOP_ADD;

    alu_decoder u_alu_dec (
        .i_aluop        (w_aluop),
        .i_funct        (bus.funct),
        .o_alu_control  (w_alu_control),
        .o_funct_illegal(w_funct_illegal)
    );

    always_comb begin
        w_next = S_FETCH;
        case (r_state)
            S_FETCH:   w_next = w_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (bus.opcode)
                    OP_LW, OP_SW:   w_next = S_MEMADR;
                    OP_R:           w_next = S_EXECUTE;
                    OP_BEQ, OP_BNE: w_next = S_BRANCH;
                    OP_ADDI:        w_next = S_ADDIEX;
                    OP_J:           w_next = S_JEX;
                    default:        w_next = S_FETCH;
                endcase
            end
            S_MEMADR:  w_next = (bus.opcode == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:   w_next = w_ready ? S_MEMWB : S_MEMRD;
            S_MEMWR:   w_next = w_ready ? S_FETCH : S_MEMWR;
            S_EXECUTE: w_next = w_funct_illegal ? S_FETCH : S_ALUWB;
            S_ADDIEX:  w_next = S_ADDIWB;
            default:   w_next = S_FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) r_state <= S_FETCH;
        else       r_state <= w_next;
    end

    // Reset forces the whole control word to zero, so no write fires that cycle.
    always_comb begin
        w_c = '0;
        if (!reset) begin
            case (r_state)
                S_FETCH: begin
                    w_c.alu_src_b = SRCB_FOUR;
                    w_c.alu_en    = 1'b1;
                    w_c.ir_write  = w_ready;
                    w_c.pc_write  = w_ready;
                end
                S_DECODE: begin
                    w_c.alu_src_b = SRCB_BRIMM;
                    w_c.alu_en    = 1'b1;
                    w_c.illegal   = !op_supported(bus.opcode);
                end
                S_MEMADR, S_ADDIEX: begin
                    w_c.alu_src_a = 1'b1;
                    w_c.alu_src_b = SRCB_IMM;
                    w_c.alu_en    = 1'b1;
                end
                S_MEMRD:  w_c.i_or_d = 1'b1;
                S_MEMWB: begin
                    w_c.mem_to_reg = 1'b1;
                    w_c.reg_write  = 1'b1;
                end
                S_MEMWR: begin
                    w_c.i_or_d    = 1'b1;
                    w_c.mem_write = 1'b1;
                end
                S_EXECUTE: begin
                    w_c.alu_src_a = 1'b1;
                    w_c.alu_src_b = SRCB_B;
                    w_c.alu_en    = 1'b1;
                    w_c.illegal   = w_funct_illegal;
                end
                S_ALUWB: begin
                    w_c.reg_dst   = 1'b1;
                    w_c.reg_write = 1'b1;
                end
                S_BRANCH: begin
                    w_c.alu_src_a = 1'b1;
                    w_c.alu_en    = 1'b1;
                    w_c.pc_src    = PCSRC_ALUOUT;
                    w_c.branch    = (bus.opcode == OP_BEQ);
                    w_c.branch_ne = (bus.opcode == OP_BNE);
                end
                S_ADDIWB: w_c.reg_write = 1'b1;
                S_JEX: begin
                    w_c.pc_src   = PCSRC_JUMP;
                    w_c.pc_write = 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.pc_en       = w_c.pc_write | (w_c.branch & bus.zero) | (w_c.branch_ne & ~bus.zero);
    assign bus.i_or_d      = w_c.i_or_d;
    assign bus.mem_write   = w_c.mem_write;
    assign bus.ir_write    = w_c.ir_write;
    assign bus.reg_dst     = w_c.reg_dst;
    assign bus.mem_to_reg  = w_c.mem_to_reg;
    assign bus.reg_write   = w_c.reg_write;
    assign bus.alu_src_a   = w_c.alu_src_a;
    assign bus.alu_src_b   = w_c.alu_src_b;
    assign bus.alu_control = w_c.alu_en ? w_alu_control : 3'b000;
    assign bus.pc_src      = w_c.pc_src;
    assign bus.illegal     = w_c.illegal;
endmodule

// File: tb/tb_mips_multicycle_control.sv
// Bench for the multicycle MIPS control FSM: vector table, hand-written wait and
// reset sequences, and random instruction streams against a micro-op list model.
module tb_mips_multicycle_control;

    // {pc_en,i_or_d,mem_write,ir_write,reg_dst,mem_to_reg,reg_write,alu_src_a,
    //  alu_src_b[1:0], alu_control[2:0], pc_src[1:0], illegal}
    localparam logic [15:0] V_ZERO    = 16'h0000;
    localparam logic [15:0] V_FETCH   = {8'b1001_0000, 2'b01, 3'b001, 2'b00, 1'b0};
    localparam logic [15:0] V_FWAIT   = {8'b0000_0000, 2'b01, 3'b001, 2'b00, 1'b0};
    localparam logic [15:0] V_DEC     = {8'b0000_0000, 2'b11, 3'b001, 2'b00, 1'b0};
    localparam logic [15:0] V_DEC_ILL = {8'b0000_0000, 2'b11, 3'b001, 2'b00, 1'b1};
    localparam logic [15:0] V_MEMADR  = {8'b0000_0001, 2'b10, 3'b001, 2'b00, 1'b0};
    localparam logic [15:0] V_MEMRD   = {8'b0100_0000, 2'b00, 3'b000, 2'b00, 1'b0};
    localparam logic [15:0] V_MEMWB   = {8'b0000_0110, 2'b00, 3'b000, 2'b00, 1'b0};
    localparam logic [15:0] V_MEMWR   = {8'b0110_0000, 2'b00, 3'b000, 2'b00, 1'b0};
    localparam logic [15:0] V_ALUWB   = {8'b0000_1010, 2'b00, 3'b000, 2'b00, 1'b0};
    localparam logic [15:0] V_ADDIWB  = {8'b0000_0010, 2'b00, 3'b000, 2'b00, 1'b0};
    localparam logic [15:0] V_JEX     = {8'b1000_0000, 2'b00, 3'b000, 2'b10, 1'b0};

    localparam logic [5:0] R = 6'b000000, LW = 6'b100011, SW = 6'b101011, BEQ = 6'b000100;
    localparam logic [5:0] BNE = 6'b000101, ADDI = 6'b001000, J = 6'b000010;

    typedef struct {
        logic [15:0] o;
        logic [15:0] w;
        bit          mem;
    } step_t;

    typedef struct {
        string       name;
        logic [5:0]  op;
        logic [5:0]  fn;
        logic        z;
        int          n;
        logic [15:0] last;
    } vec_t;

    logic  clk = 1'b0;
    logic  reset = 1'b1;
    int    n_checks = 0;
    int    n_errors = 0;
    step_t mq[$];

    mips_multicycle_control_if bus();

    mips_multicycle_control #(.HONOR_MEM_READY(1'b1)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] vbr(input logic pc);
        return {pc, 7'b000_0001, 2'b00, 3'b101, 2'b01, 1'b0};
    endfunction

    function automatic logic [15:0] vex(input logic [2:0] aluc, input logic ill);
        return {8'b0000_0001, 2'b00, aluc, 2'b00, ill};
    endfunction

    function automatic logic [15:0] sample();
        return {bus.pc_en, bus.i_or_d, bus.mem_write, bus.ir_write, bus.reg_dst,
                bus.mem_to_reg, bus.reg_write, bus.alu_src_a, bus.alu_src_b,
                bus.alu_control, bus.pc_src, bus.illegal};
    endfunction

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %b, expected %b", name, act, exp);
        end
    endtask

    // One clock cycle: drive inputs just after the edge, sample at the falling edge.
    task automatic cyc(input logic rdy, input logic rst, input logic [5:0] op,
                       input logic [5:0] fn, input logic z, output logic [15:0] act);
        @(posedge clk);
        #1;
        bus.mem_ready = rdy;
        reset         = rst;
        bus.opcode    = op;
        bus.funct     = fn;
        bus.zero      = z;
        @(negedge clk);
        act = sample();
    endtask

    function automatic void push(input logic [15:0] o, input logic [15:0] w, input bit m);
        step_t s;
        s.o = o; s.w = w; s.mem = m;
        mq.push_back(s);
    endfunction

    // Reference: the list of cycles an instruction takes, with the output seen
    // in each; memory steps repeat their wait view while mem_ready is low.
    task automatic build(input logic [5:0] op, input logic [5:0] fn, input logic z);
        logic [2:0] aluc;
        logic       ill;
        mq.delete();
        push(V_FETCH, V_FWAIT, 1);
        push((op inside {R, LW, SW, BEQ, BNE, ADDI, J}) ? V_DEC : V_DEC_ILL, 16'h0, 0);
        case (op)
            LW: begin
                push(V_MEMADR, 16'h0, 0);
                push(V_MEMRD, V_MEMRD, 1);
                push(V_MEMWB, 16'h0, 0);
            end
            SW: begin
                push(V_MEMADR, 16'h0, 0);
                push(V_MEMWR, V_MEMWR, 1);
            end
            R: begin
                ill = 1'b0;
                case (fn)
                    6'b100000: aluc = 3'b001;
                    6'b100010: aluc = 3'b101;
                    6'b100100: aluc = 3'b011;
                    6'b100101: aluc = 3'b010;
                    6'b101010: aluc = 3'b100;
                    default: begin aluc = 3'b001; ill = 1'b1; end
                endcase
                push(vex(aluc, ill), 16'h0, 0);
                if (!ill) push(V_ALUWB, 16'h0, 0);
            end
            BEQ:  push(vbr(z), 16'h0, 0);
            BNE:  push(vbr(!z), 16'h0, 0);
            ADDI: begin
                push(V_MEMADR, 16'h0, 0);
                push(V_ADDIWB, 16'h0, 0);
            end
            J:    push(V_JEX, 16'h0, 0);
            default: ;
        endcase
    endtask

    task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input logic z, input bit rnd);
        logic [15:0] act;
        logic        rdy;
        int          waits;
        build(op, fn, z);
        foreach (mq[i]) begin
            waits = 0;
            do begin
                rdy = (!rnd || waits >= 4 || $urandom_range(0, 3) != 0);
                cyc(rdy, 1'b0, op, fn, z, act);
                chk($sformatf("op=%b fn=%b step%0d", op, fn, i), act,
                    (mq[i].mem && !rdy) ? mq[i].w : mq[i].o);
                waits++;
            end while (mq[i].mem && !rdy);
        end
    endtask

    initial begin
        logic [15:0] act;
        vec_t        tbl[12];
        logic [5:0]  ops[8];
        logic [5:0]  fns[6];
        logic [5:0]  op;
        logic [5:0]  fn;

        tbl[0]  = '{"lw",      LW,   6'b0,      1'b0, 5, V_MEMWB};
        tbl[1]  = '{"sw",      SW,   6'b0,      1'b0, 4, V_MEMWR};
        tbl[2]  = '{"r_sub",   R,    6'b100010, 1'b0, 4, V_ALUWB};
        tbl[3]  = '{"r_slt",   R,    6'b101010, 1'b0, 4, V_ALUWB};
        tbl[4]  = '{"r_badfn", R,    6'b000000, 1'b0, 3, vex(3'b001, 1'b1)};
        tbl[5]  = '{"addi",    ADDI, 6'b0,      1'b0, 4, V_ADDIWB};
        tbl[6]  = '{"beq_z1",  BEQ,  6'b0,      1'b1, 3, vbr(1'b1)};
        tbl[7]  = '{"beq_z0",  BEQ,  6'b0,      1'b0, 3, vbr(1'b0)};
        tbl[8]  = '{"bne_z1",  BNE,  6'b0,      1'b1, 3, vbr(1'b0)};
        tbl[9]  = '{"bne_z0",  BNE,  6'b0,      1'b0, 3, vbr(1'b1)};
        tbl[10] = '{"j",       J,    6'b0,      1'b0, 3, V_JEX};
        tbl[11] = '{"bad_op",  6'b111111, 6'b0, 1'b0, 2, V_DEC_ILL};

        bus.mem_ready = 1'b1;
        bus.opcode    = LW;
        bus.funct     = 6'b0;
        bus.zero      = 1'b0;

        // Reset held three cycles, then a full LW.
        for (int i = 0; i < 3; i++) begin
            cyc(1'b1, 1'b1, LW, 6'b0, 1'b0, act);
            chk($sformatf("reset cycle %0d", i), act, V_ZERO);
        end
        cyc(1'b1, 1'b0, LW, 6'b0, 1'b0, act); chk("lw fetch",  act, V_FETCH);
        cyc(1'b1, 1'b0, LW, 6'b0, 1'b0, act); chk("lw decode", act, V_DEC);
        cyc(1'b1, 1'b0, LW, 6'b0, 1'b0, act); chk("lw memadr", act, V_MEMADR);
        cyc(1'b1, 1'b0, LW, 6'b0, 1'b0, act); chk("lw memrd",  act, V_MEMRD);
        cyc(1'b1, 1'b0, LW, 6'b0, 1'b0, act); chk("lw memwb",  act, V_MEMWB);

        // Each entry: first cycle must be FETCH, cycle n is the entry's last state.
        for (int t = 0; t < 12; t++) begin
            for (int k = 1; k <= tbl[t].n; k++) begin
                cyc(1'b1, 1'b0, tbl[t].op, tbl[t].fn, tbl[t].z, act);
                if (k == 1) chk({tbl[t].name, " fetch"}, act, V_FETCH);
                if (k == tbl[t].n) chk({tbl[t].name, " last"}, act, tbl[t].last);
            end
        end

        // SW with two wait cycles in MEMWR, then a FETCH with one wait.
        cyc(1'b1, 1'b0, SW, 6'b0, 1'b0, act); chk("sw fetch",  act, V_FETCH);
        cyc(1'b1, 1'b0, SW, 6'b0, 1'b0, act); chk("sw decode", act, V_DEC);
        cyc(1'b1, 1'b0, SW, 6'b0, 1'b0, act); chk("sw memadr", act, V_MEMADR);
        cyc(1'b0, 1'b0, SW, 6'b0, 1'b0, act); chk("sw wait1",  act, V_MEMWR);
        cyc(1'b0, 1'b0, SW, 6'b0, 1'b0, act); chk("sw wait2",  act, V_MEMWR);
        cyc(1'b1, 1'b0, SW, 6'b0, 1'b0, act); chk("sw memwr",  act, V_MEMWR);
        cyc(1'b0, 1'b0, J,  6'b0, 1'b0, act); chk("fetch wait", act, V_FWAIT);
        cyc(1'b1, 1'b0, J,  6'b0, 1'b0, act); chk("fetch go",  act, V_FETCH);
        cyc(1'b1, 1'b0, J,  6'b0, 1'b0, act); chk("j decode",  act, V_DEC);
        cyc(1'b1, 1'b0, J,  6'b0, 1'b0, act); chk("j jex",     act, V_JEX);

        // Reset landing in MEMRD aborts the load.
        cyc(1'b1, 1'b0, LW, 6'b0, 1'b0, act); chk("abort fetch",  act, V_FETCH);
        cyc(1'b1, 1'b0, LW, 6'b0, 1'b0, act); chk("abort decode", act, V_DEC);
        cyc(1'b1, 1'b0, LW, 6'b0, 1'b0, act); chk("abort memadr", act, V_MEMADR);
        cyc(1'b1, 1'b1, LW, 6'b0, 1'b0, act); chk("abort reset",  act, V_ZERO);
        cyc(1'b1, 1'b0, J,  6'b0, 1'b0, act); chk("abort refetch", act, V_FETCH);
        cyc(1'b1, 1'b0, J,  6'b0, 1'b0, act); chk("abort decode2", act, V_DEC);
        cyc(1'b1, 1'b0, J,  6'b0, 1'b0, act); chk("abort jex",     act, V_JEX);

        // Random instruction stream with random memory stalls.
        ops = '{R, LW, SW, BEQ, BNE, ADDI, J, 6'b111111};
        fns = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b000000};
        for (int n = 0; n < 300; n++) begin
            op = ops[$urandom_range(0, 7)];
            if (op == 6'b111111) op = 6'(($urandom_range(0, 63) | 32'd48));
            fn = ($urandom_range(0, 4) != 0) ? fns[$urandom_range(0, 5)] : 6'($urandom_range(0, 63));
            run_instr(op, fn, 1'($urandom_range(0, 1)), 1'b1);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
